poly_sub_mod_q: RTL and testbench

Streaming modular subtractor for Kyber768 polynomials. It accepts one coefficient pair per handshake, computes (in1 − in2) mod q with q = 3329, and emits the 256 results of one polynomial in order. It is the subtract-side counterpart of the adder datapath: decapsulation uses it for m' = v − sᵀu, and it also serves compress-error checks. Two-stage pipeline with valid/ready backpressure, a coefficient counter and a per-polynomial control FSM.

---
 rtl/poly_sub_mod_q_pkg.sv | 39 +++
 rtl/poly_sub_mod_q_if.sv | 35 +++
 rtl/poly_sub_mod_q_reduce.sv | 25 ++
 rtl/poly_sub_mod_q.sv | 163 ++++++++++++++++
 tb/tb_poly_sub_mod_q.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/poly_sub_mod_q_pkg.sv
// ---------------------------------------------------------------------------
// kyber_pkg
// Shared Kyber constants, the per-polynomial FSM state type and the modular
// subtraction helper. This package is also used by the adder and NTT blocks.
// No ports (package).
// ---------------------------------------------------------------------------
package kyber_pkg;

   localparam int DATA_WID = 12;
   localparam int N_COEF   = 256;
   localparam int CNT_WID  = $clog2(N_COEF);

   localparam logic [DATA_WID-1:0] Q        = 12'd3329;
   localparam logic [CNT_WID-1:0]  LAST_IDX = CNT_WID'(N_COEF - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } poly_state_e;

   // (a - b) mod Q for a, b already in 0..Q-1. The 13th bit of the raw
   // difference is the borrow; adding Q back once lands in range.
   function automatic logic [DATA_WID-1:0] sub_mod_q(
      input logic [DATA_WID-1:0] a,
      input logic [DATA_WID-1:0] b
   );
      logic [DATA_WID:0] t;
      logic [DATA_WID:0] r;
      t = {1'b0, a} - {1'b0, b};
      if (t[DATA_WID]) begin
         r = t + {1'b0, Q};
      end else begin
         r = t;
      end
      return r[DATA_WID-1:0];
   endfunction

endpackage

// File: rtl/poly_sub_mod_q_if.sv
// ---------------------------------------------------------------------------
// poly_sub_mod_q_if
// Bundles the control, input-pair stream and result stream of the modular
// subtractor.
//   master (producer/consumer side): drives start, in_valid, in1, in2,
//                                    out_ready; observes the rest
//   slave  (subtractor side):        drives in_ready, out_valid, diff,
//                                    last, busy, done
// ---------------------------------------------------------------------------
interface poly_sub_mod_q_if;
   import kyber_pkg::*;

   logic                start;
   logic                in_valid;
   logic                in_ready;
   logic [DATA_WID-1:0] in1;
   logic [DATA_WID-1:0] in2;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_WID-1:0] diff;
   logic                last;
   logic                busy;
   logic                done;

   modport master (
      output start, in_valid, in1, in2, out_ready,
      input  in_ready, out_valid, diff, last, busy, done
   );

   modport slave (
      input  start, in_valid, in1, in2, out_ready,
      output in_ready, out_valid, diff, last, busy, done
   );

endinterface

// File: rtl/poly_sub_mod_q_reduce.sv
// ---------------------------------------------------------------------------
// mod_q_reduce_once
// Combinational conditional subtract: y = (x >= Q) ? x - Q : x.
// Any 12-bit input is below 2Q, so a single subtraction fully reduces it.
//   x : in  DATA_WID  raw value 0..4095
//   y : out DATA_WID  reduced value 0..Q-1
// ---------------------------------------------------------------------------
module mod_q_reduce_once
   import kyber_pkg::*;
(
   input  logic [DATA_WID-1:0] x,
   output logic [DATA_WID-1:0] y
);

   // Conditional subtraction of the modulus.
   always_comb begin
      y = x;
      if (x >= Q) begin
         y = x - Q;
      end else begin
         y = x;
      end
   end

endmodule

// File: rtl/poly_sub_mod_q.sv
// ---------------------------------------------------------------------------
// poly_sub_mod_q
// Streaming (in1 - in2) mod Q for one Kyber polynomial of N_COEF
// coefficients. Stage 1 reduces both operands, stage 2 subtracts and
// registers the result together with its last flag. Valid/ready with full
// hold on output stall.
//   clk   : in   rising-edge clock
//   rst_n : in   asynchronous active-low reset
//   bus   : slave modport of poly_sub_mod_q_if (start, in_valid/in_ready,
//           in1, in2, out_valid/out_ready, diff, last, busy, done)
// ---------------------------------------------------------------------------
module poly_sub_mod_q
   import kyber_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   poly_sub_mod_q_if.slave  bus
);

   poly_state_e         state_q,     state_d;
   logic [CNT_WID-1:0]  in_cnt_q,    in_cnt_d;
   logic [CNT_WID-1:0]  out_cnt_q,   out_cnt_d;
   logic                s1_valid_q,  s1_valid_d;
   logic [DATA_WID-1:0] a_q,         a_d;
   logic [DATA_WID-1:0] b_q,         b_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_WID-1:0] diff_q,      diff_d;
   logic                last_q,      last_d;
   logic                done_q,      done_d;

   logic [DATA_WID-1:0] a_red_s;
   logic [DATA_WID-1:0] b_red_s;
   logic                stall_s;
   logic                in_ready_s;
   logic                accept_s;
   logic                xfer_s;
   logic [CNT_WID-1:0]  out_idx_s;

   mod_q_reduce_once u_red_a (.x(bus.in1), .y(a_red_s));
   mod_q_reduce_once u_red_b (.x(bus.in2), .y(b_red_s));

   assign stall_s    = out_valid_q && !bus.out_ready;
   assign in_ready_s = (state_q == ST_RUN) && !stall_s;
   assign accept_s   = bus.in_valid && in_ready_s;
   assign xfer_s     = out_valid_q && bus.out_ready;

   // Index of the result about to enter stage 2: the transferred count,
   // plus one if the result currently held is leaving on this edge.
   assign out_idx_s  = out_cnt_q + CNT_WID'(out_valid_q);

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.last      = last_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;

   // Next-state computation for pipeline, counters and FSM.
   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      s1_valid_d  = s1_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      last_d      = last_q;
      done_d      = 1'b0;

      // Pipeline advances only when the output register is free to move.
      if (!stall_s) begin
         s1_valid_d  = accept_s;
         out_valid_d = s1_valid_q;
         if (accept_s) begin
            a_d = a_red_s;
            b_d = b_red_s;
         end else begin
            a_d = a_q;
            b_d = b_q;
         end
         if (s1_valid_q) begin
            diff_d = sub_mod_q(a_q, b_q);
            last_d = (out_idx_s == LAST_IDX);
         end else begin
            diff_d = diff_q;
            last_d = last_q;
         end
      end else begin
         s1_valid_d  = s1_valid_q;
         out_valid_d = out_valid_q;
      end

      if (xfer_s) begin
         out_cnt_d = out_cnt_q + {{(CNT_WID-1){1'b0}}, 1'b1};
      end else begin
         out_cnt_d = out_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d   = ST_RUN;
               in_cnt_d  = {CNT_WID{1'b0}};
               out_cnt_d = {CNT_WID{1'b0}};
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s) begin
               in_cnt_d = in_cnt_q + {{(CNT_WID-1){1'b0}}, 1'b1};
               if (in_cnt_q == LAST_IDX) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (xfer_s && last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_cnt_q    <= {CNT_WID{1'b0}};
         out_cnt_q   <= {CNT_WID{1'b0}};
         s1_valid_q  <= 1'b0;
         a_q         <= {DATA_WID{1'b0}};
         b_q         <= {DATA_WID{1'b0}};
         out_valid_q <= 1'b0;
         diff_q      <= {DATA_WID{1'b0}};
         last_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_poly_sub_mod_q.sv
// ---------------------------------------------------------------------------
// tb_poly_sub_mod_q
// Directed bench for the streaming modular subtractor. Inputs change and
// outputs are sampled 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_poly_sub_mod_q;
   import kyber_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   poly_sub_mod_q_if bus ();

   poly_sub_mod_q dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int pass_cnt  = 0;
   int check_cnt = 0;
   int fail_cnt  = 0;

   int vec1 [256];
   int vec2 [256];
   int hand1 [7] = '{5, 3, 0, 3329, 4095, 0, 3328};
   int hand2 [7] = '{3, 5, 3328, 3329, 0, 4095, 0};
   int hand_exp [7] = '{2, 3327, 1, 0, 766, 2563, 3328};
   bit use_hand;

   int exp_q [$];
   int feed_idx, out_idx, cyc, first_acc, first_out;
   bit stall_prev, last_xfer_prev;
   int prev_diff, prev_last;

   task automatic check(input string tag, input int obs, input int exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_sub(input int a, input int b);
      return ((a % 3329) - (b % 3329) + 3329) % 3329;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         vec1[i] = $urandom_range(0, 4095);
         vec2[i] = $urandom_range(0, 4095);
      end
   endtask

   // One clock cycle: drive, settle, observe.
   task automatic step(input bit rdy, input bit st);
      int e;
      @(negedge clk);
      bus.out_ready = rdy;
      bus.start     = st;
      bus.in_valid  = (feed_idx < 256);
      if (feed_idx < 256) begin
         bus.in1 = 12'(vec1[feed_idx]);
         bus.in2 = 12'(vec2[feed_idx]);
      end
      #1;
      cyc++;
      check("done", int'(bus.done), int'(last_xfer_prev));
      last_xfer_prev = 1'b0;
      if (stall_prev) begin
         check("hold_valid", int'(bus.out_valid), 1);
         check("hold_diff",  int'(bus.diff), prev_diff);
         check("hold_last",  int'(bus.last), prev_last);
      end
      if (bus.out_valid && !bus.out_ready) begin
         check("stall_in_ready", int'(bus.in_ready), 0);
      end
      if (bus.in_valid && bus.in_ready) begin
         if (use_hand && feed_idx < 7) begin
            exp_q.push_back(hand_exp[feed_idx]);
         end else begin
            exp_q.push_back(ref_sub(vec1[feed_idx], vec2[feed_idx]));
         end
         if (feed_idx == 0) first_acc = cyc;
         feed_idx++;
      end
      if (bus.out_valid && first_out < 0) first_out = cyc;
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_output", out_idx, -1);
         end else begin
            e = exp_q.pop_front();
            check("diff", int'(bus.diff), e);
         end
         check("last", int'(bus.last), int'(out_idx == 255));
         last_xfer_prev = bus.last;
         out_idx++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_diff  = int'(bus.diff);
      prev_last  = int'(bus.last);
   endtask

   task automatic begin_poly();
      exp_q.delete();
      feed_idx = 0; out_idx = 0; first_acc = -1; first_out = -1;
      stall_prev = 1'b0; last_xfer_prev = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.in_valid = 1'b1;
      bus.in1 = 12'd9; bus.in2 = 12'd0; bus.out_ready = 1'b1;
      #1;
      check("start_cycle_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      bus.start = 1'b0; bus.in_valid = 1'b0;
      #1;
      check("busy_after_start",     int'(bus.busy), 1);
      check("in_ready_after_start", int'(bus.in_ready), 1);
   endtask

   // Runs until all 256 results are out, or until abort_at pairs are fed.
   task automatic run_poly(input bit bp, input int abort_at);
      int guard = 0;
      while (out_idx < 256 && (abort_at < 0 || feed_idx < abort_at) && guard < 3000) begin
         step(bp ? 1'($urandom_range(0, 1)) : 1'b1, (feed_idx == 50) || (feed_idx == 256));
         guard++;
      end
      bus.start = 1'b0;
      if (abort_at < 0) begin
         check("poly_complete", out_idx, 256);
         step(1'b1, 1'b0);
         check("busy_with_done", int'(bus.busy), 0);
         step(1'b1, 1'b0);
         check("no_output_after", int'(bus.out_valid), 0);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in1 = 12'd0;
      bus.in2 = 12'd0; bus.out_ready = 1'b0;
      cyc = 0; use_hand = 1'b0;
      feed_idx = 256; out_idx = 0; first_acc = -1; first_out = -1;
      stall_prev = 1'b0; last_xfer_prev = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready",  int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_diff",      int'(bus.diff), 0);
      check("rst_last",      int'(bus.last), 0);
      check("rst_busy",      int'(bus.busy), 0);
      check("rst_done",      int'(bus.done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // in_valid while idle is never accepted
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in1 = 12'd7; bus.in2 = 12'd1; bus.out_ready = 1'b1;
      #1;
      check("idle_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("idle_no_output", int'(bus.out_valid), 0);

      // Poly 1: hand-computed boundary pairs first, no backpressure,
      // start pulses in RUN and DRAIN
      fill_random();
      for (int i = 0; i < 7; i++) begin
         vec1[i] = hand1[i];
         vec2[i] = hand2[i];
      end
      use_hand = 1'b1;
      begin_poly();
      run_poly(1'b0, -1);
      check("latency", first_out - first_acc, 2);
      use_hand = 1'b0;

      // Poly 2: random data, 50% backpressure
      fill_random();
      begin_poly();
      run_poly(1'b1, -1);

      // Poly 3: reset at coefficient 100
      fill_random();
      begin_poly();
      run_poly(1'b1, 100);
      check("abort_fed", feed_idx, 100);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_in_ready",  int'(bus.in_ready), 0);
      check("midrst_busy",      int'(bus.busy), 0);
      check("midrst_diff",      int'(bus.diff), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Poly 4: fresh polynomial must restart at index 0 with no stale data
      fill_random();
      begin_poly();
      run_poly(1'b1, -1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
